toast_wb_arbiter: RTL and testbench
===================================

TOAST_WB_ARBITER -- requirements
Module: toast_wb_arbiter

Interface
REQ-001 SHALL have parameter REG_DATA_WIDTH, default 32, register data width.
REQ-002 SHALL have parameter REGFILE_ADDR_WIDTH, default 5, register address width.
REQ-003 SHALL have parameter REGFILE_DEPTH, default 32, number of architectural registers.
REQ-004 SHALL have parameter STARVE_LIMIT, default 4, cycles the M port may wait before it takes priority.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port resetn_i, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have ports p_valid_i (in, 1), p_ready_o (out, 1), p_rd_addr_i (in, REGFILE_ADDR_WIDTH) and p_rd_data_i (in, REG_DATA_WIDTH): the pipeline writeback request.
REQ-008 SHALL have ports m_valid_i (in, 1), m_ready_o (out, 1), m_rd_addr_i (in, REGFILE_ADDR_WIDTH) and m_rd_data_i (in, REG_DATA_WIDTH): the multi-cycle unit writeback request.
REQ-009 SHALL have ports issue_en_i (in, 1) and issue_rd_i (in, REGFILE_ADDR_WIDTH): a multi-cycle op is issued with destination issue_rd_i.
REQ-010 SHALL have ports rs1_addr_i and rs2_addr_i (in, REGFILE_ADDR_WIDTH), and rs1_busy_o and rs2_busy_o (out, 1): hazard query.
REQ-011 SHALL have ports rd_wr_en_o (out, 1), rd_addr_o (out, REGFILE_ADDR_WIDTH) and rd_wr_data_o (out, REG_DATA_WIDTH): the register file write port.

Function
REQ-012 SHALL complete a transfer on a port in any cycle where its valid and ready are both 1; at most one transfer per cycle.
REQ-013 SHALL implement FSM states P_PRIO and M_PRIO.
- Reset state: P_PRIO.
REQ-014 SHALL drive ready as follows:
- In P_PRIO: p_ready_o=1 and m_ready_o=!p_valid_i.
- In M_PRIO: p_ready_o=0 and m_ready_o=1.
REQ-015 SHALL keep a starvation counter, saturating at STARVE_LIMIT-1.
- Increments in P_PRIO when m_valid_i=1 and no M transfer occurs.
- Clears on any M transfer or when m_valid_i=0.
REQ-016 SHALL move P_PRIO->M_PRIO when the counter equals STARVE_LIMIT-1, m_valid_i=1 and no M transfer occurs this cycle.
REQ-017 SHALL move M_PRIO->P_PRIO on an M transfer, or if m_valid_i=0 (request withdrawn), and clear the counter in both cases.
REQ-018 SHALL register the write: a transfer in cycle N drives rd_wr_en_o=1 and that transfer's addr/data on rd_addr_o/rd_wr_data_o in cycle N+1.
- rd_wr_en_o=0 in cycles following no transfer.
REQ-019 SHALL accept a transfer addressed to x0 (handshake completes) but keep rd_wr_en_o=0 for it.
REQ-020 SHALL keep a REGFILE_DEPTH-bit pending scoreboard.
- issue_en_i sets bit issue_rd_i.
- An M transfer clears bit m_rd_addr_i.
- P transfers never change the scoreboard.
REQ-021 SHALL resolve a same-cycle issue and M clear to the same register as set wins; issue to x0 is ignored.
REQ-022 SHALL drive rsN_busy_o = pending[rsN_addr_i] combinationally; x0 is never busy.
- A cleared bit deasserts busy in the same cycle rd_wr_en_o asserts, so the register-file bypass supplies the data.
REQ-023 SHALL NOT assume requesters hold addr/data stable; values are sampled only in the transfer cycle.

Reset
REQ-024 SHALL, on resetn_i low, asynchronously set state=P_PRIO, counter=0, scoreboard=0, rd_wr_en_o=0, rd_addr_o=0 and rd_wr_data_o=0.
REQ-025 SHALL drop a write registered but not yet presented when reset hits mid-operation; after release the block resumes from the reset state.

Structure
REQ-026 SHALL place the FSM state enum (P_PRIO, M_PRIO) and the STARVE_LIMIT default in toast_def_pkg.
REQ-027 SHALL implement the scoreboard as sub-module toast_scoreboard (set/clear/two read ports); arbitration and the output register stay in the top module.

Verification
REQ-028 SHALL cover P-only traffic: p_valid_i=1, addr 5, data 0xA5 -> p_ready_o=1; next cycle rd_wr_en_o=1, rd_addr_o=5, rd_wr_data_o=0xA5.
REQ-029 SHALL cover starvation: p_valid_i and m_valid_i held 1 (M addr 7) -> M blocked 4 cycles; 5th cycle p_ready_o=0 and M transfers; write to x7 the next cycle; then P_PRIO.
REQ-030 SHALL cover the scoreboard: issue rd=9, then query rs1=9 -> rs1_busy_o=1; M transfer to 9 -> busy 0 in the cycle rd_wr_en_o=1.
REQ-031 SHALL cover a simultaneous event: issue rd=3 in the same cycle as an M transfer to 3 -> rs2_addr_i=3 reads busy=1 afterwards.
REQ-032 SHALL cover x0: P transfer to x0 -> handshake completes, rd_wr_en_o stays 0; issue rd=0 -> busy stays 0.
REQ-033 SHALL cover reset mid-operation: assert resetn_i low between a transfer and its write cycle -> rd_wr_en_o=0 immediately, scoreboard and state return to reset values.

Source files
------------

// File: rtl/toast_def_pkg.sv
// Shared definitions for the writeback arbiter: FSM state encoding and
// the default starvation threshold.
package toast_def_pkg;

  typedef enum logic {
    P_PRIO = 1'b0,
    M_PRIO = 1'b1
  } arb_state_e;

  localparam int STARVE_LIMIT_DEF = 4;

  // Bits needed to hold 0..limit-1 (at least one bit).
  function automatic int starve_cnt_width(input int limit);
    return (limit <= 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/toast_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set on issue,
// cleared on multi-cycle writeback, with two combinational read ports.
module toast_scoreboard #(
  parameter int REGFILE_ADDR_WIDTH = 5,
  parameter int REGFILE_DEPTH      = 32
) (
  input  logic                          clk_i,
  input  logic                          resetn_i,
  input  logic                          set_en_i,
  input  logic [REGFILE_ADDR_WIDTH-1:0] set_addr_i,
  input  logic                          clr_en_i,
  input  logic [REGFILE_ADDR_WIDTH-1:0] clr_addr_i,
  input  logic [REGFILE_ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [REGFILE_ADDR_WIDTH-1:0] rs2_addr_i,
  output logic                          rs1_busy_o,
  output logic                          rs2_busy_o
);

  // Spans the whole address space so lookups index it directly; x0 and
  // addresses beyond the register file are tied to zero.
  localparam int SPAN = 1 << REGFILE_ADDR_WIDTH;

  logic [SPAN-1:0] pending;

  generate
    for (genvar gi = 0; gi < SPAN; gi++) begin : g_bit
      if (gi == 0 || gi >= REGFILE_DEPTH) begin : g_tied
        assign pending[gi] = 1'b0;
      end else begin : g_flop
        logic bit_reg;
        logic set_hit;
        logic clr_hit;

        assign set_hit = set_en_i && (set_addr_i == REGFILE_ADDR_WIDTH'(gi));
        assign clr_hit = clr_en_i && (clr_addr_i == REGFILE_ADDR_WIDTH'(gi));

        // A new issue outranks the retiring writeback of the same register.
        always_ff @(posedge clk_i or negedge resetn_i) begin
          if (!resetn_i) begin
            bit_reg <= 1'b0;
          end else if (set_hit) begin
            bit_reg <= 1'b1;
          end else if (clr_hit) begin
            bit_reg <= 1'b0;
          end
        end

        assign pending[gi] = bit_reg;
      end
    end
  endgenerate

  assign rs1_busy_o = pending[rs1_addr_i];
  assign rs2_busy_o = pending[rs2_addr_i];

endmodule

// File: rtl/toast_wb_arbiter.sv
// Writeback arbiter: shares one register-file write port between the pipeline
// (P) and a multi-cycle unit (M), with starvation relief for M.
module toast_wb_arbiter
  import toast_def_pkg::*;
#(
  parameter int REG_DATA_WIDTH     = 32,
  parameter int REGFILE_ADDR_WIDTH = 5,
  parameter int REGFILE_DEPTH      = 32,
  parameter int STARVE_LIMIT       = STARVE_LIMIT_DEF
) (
  input  logic                          clk_i,
  input  logic                          resetn_i,
  input  logic                          p_valid_i,
  output logic                          p_ready_o,
  input  logic [REGFILE_ADDR_WIDTH-1:0] p_rd_addr_i,
  input  logic [REG_DATA_WIDTH-1:0]     p_rd_data_i,
  input  logic                          m_valid_i,
  output logic                          m_ready_o,
  input  logic [REGFILE_ADDR_WIDTH-1:0] m_rd_addr_i,
  input  logic [REG_DATA_WIDTH-1:0]     m_rd_data_i,
  input  logic                          issue_en_i,
  input  logic [REGFILE_ADDR_WIDTH-1:0] issue_rd_i,
  input  logic [REGFILE_ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [REGFILE_ADDR_WIDTH-1:0] rs2_addr_i,
  output logic                          rs1_busy_o,
  output logic                          rs2_busy_o,
  output logic                          rd_wr_en_o,
  output logic [REGFILE_ADDR_WIDTH-1:0] rd_addr_o,
  output logic [REG_DATA_WIDTH-1:0]     rd_wr_data_o
);

  localparam int CW = starve_cnt_width(STARVE_LIMIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT - 1);

  arb_state_e                    state_reg, state_next;
  logic [CW-1:0]                 cnt_reg, cnt_next;
  logic                          p_ready, m_ready;
  logic                          p_xfer, m_xfer;
  logic                          wr_en_next;
  logic [REGFILE_ADDR_WIDTH-1:0] wr_addr_next;
  logic [REG_DATA_WIDTH-1:0]     wr_data_next;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_reg <= P_PRIO;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    p_ready    = 1'b0;
    m_ready    = 1'b0;
    p_xfer     = 1'b0;
    m_xfer     = 1'b0;
    case (state_reg)
      P_PRIO: begin
        p_ready = 1'b1;
        m_ready = !p_valid_i;
        p_xfer  = p_valid_i;
        m_xfer  = m_valid_i && !p_valid_i;
        if (!m_valid_i || m_xfer) begin
          cnt_next = '0;
        end else if (cnt_reg == CNT_MAX) begin
          // M refused once more at the limit: give it the port next cycle.
          state_next = M_PRIO;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      M_PRIO: begin
        m_ready = 1'b1;
        m_xfer  = m_valid_i;
        // Either M is served now or it withdrew; both return control to P.
        state_next = P_PRIO;
        cnt_next   = '0;
      end
      default: begin
        state_next = P_PRIO;
        cnt_next   = '0;
      end
    endcase
  end

  assign p_ready_o = p_ready;
  assign m_ready_o = m_ready;

  // At most one of p_xfer/m_xfer is ever set; x0 writes are swallowed here.
  always_comb begin
    wr_addr_next = m_xfer ? m_rd_addr_i : p_rd_addr_i;
    wr_data_next = m_xfer ? m_rd_data_i : p_rd_data_i;
    wr_en_next   = (p_xfer || m_xfer) && (wr_addr_next != '0);
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      rd_wr_en_o   <= 1'b0;
      rd_addr_o    <= '0;
      rd_wr_data_o <= '0;
    end else begin
      rd_wr_en_o <= wr_en_next;
      if (wr_en_next) begin
        rd_addr_o    <= wr_addr_next;
        rd_wr_data_o <= wr_data_next;
      end
    end
  end

  toast_scoreboard #(
    .REGFILE_ADDR_WIDTH(REGFILE_ADDR_WIDTH),
    .REGFILE_DEPTH     (REGFILE_DEPTH)
  ) u_scoreboard (
    .clk_i     (clk_i),
    .resetn_i  (resetn_i),
    .set_en_i  (issue_en_i),
    .set_addr_i(issue_rd_i),
    .clr_en_i  (m_xfer),
    .clr_addr_i(m_rd_addr_i),
    .rs1_addr_i(rs1_addr_i),
    .rs2_addr_i(rs2_addr_i),
    .rs1_busy_o(rs1_busy_o),
    .rs2_busy_o(rs2_busy_o)
  );

endmodule

// File: tb/tb_toast_wb_arbiter.sv
// Bench for toast_wb_arbiter: directed vector table, a reset-mid-operation
// sequence, then random traffic against a rule-level reference model.
module tb_toast_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int STARVE_LIMIT = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          p_valid, p_ready;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_data;
  logic          m_valid, m_ready;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          issue_en;
  logic [AW-1:0] issue_rd;
  logic [AW-1:0] rs1, rs2;
  logic          busy1, busy2;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  toast_wb_arbiter #(
    .REG_DATA_WIDTH    (DW),
    .REGFILE_ADDR_WIDTH(AW),
    .REGFILE_DEPTH     (32),
    .STARVE_LIMIT      (STARVE_LIMIT)
  ) dut (
    .clk_i       (clk),
    .resetn_i    (resetn),
    .p_valid_i   (p_valid),
    .p_ready_o   (p_ready),
    .p_rd_addr_i (p_addr),
    .p_rd_data_i (p_data),
    .m_valid_i   (m_valid),
    .m_ready_o   (m_ready),
    .m_rd_addr_i (m_addr),
    .m_rd_data_i (m_data),
    .issue_en_i  (issue_en),
    .issue_rd_i  (issue_rd),
    .rs1_addr_i  (rs1),
    .rs2_addr_i  (rs2),
    .rs1_busy_o  (busy1),
    .rs2_busy_o  (busy2),
    .rd_wr_en_o  (wr_en),
    .rd_addr_o   (wr_addr),
    .rd_wr_data_o(wr_data)
  );

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic          pv;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    logic          mv;
    logic [AW-1:0] ma;
    logic [DW-1:0] md;
    logic          ie;
    logic [AW-1:0] ir;
    logic [AW-1:0] r1;
    logic [AW-1:0] r2;
    logic          e_pr;
    logic          e_mr;
    logic          e_we;
    logic [AW-1:0] e_wa;
    logic [DW-1:0] e_wd;
    logic          e_b1;
    logic          e_b2;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic pv, input int pa, input int pd,
    input logic mv, input int ma, input int md,
    input logic ie, input int ir, input int r1, input int r2,
    input logic e_pr, input logic e_mr, input logic e_we,
    input int e_wa, input int e_wd, input logic e_b1, input logic e_b2);
    vec_t v;
    v.pv = pv; v.pa = AW'(pa); v.pd = DW'(pd);
    v.mv = mv; v.ma = AW'(ma); v.md = DW'(md);
    v.ie = ie; v.ir = AW'(ir); v.r1 = AW'(r1); v.r2 = AW'(r2);
    v.e_pr = e_pr; v.e_mr = e_mr; v.e_we = e_we;
    v.e_wa = AW'(e_wa); v.e_wd = DW'(e_wd); v.e_b1 = e_b1; v.e_b2 = e_b2;
    return v;
  endfunction

  task automatic drive_idle();
    p_valid = 0; p_addr = '0; p_data = '0;
    m_valid = 0; m_addr = '0; m_data = '0;
    issue_en = 0; issue_rd = '0; rs1 = '0; rs2 = '0;
  endtask

  // Reference model state: consecutive refusals of a waiting M request,
  // set of registers with a write outstanding, and the write due next cycle.
  int            refused;
  bit            pend[32];
  logic          exp_we;
  logic [AW-1:0] exp_wa;
  logic [DW-1:0] exp_wd;

  initial begin
    resetn = 0;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("reset p_ready", p_ready, 1);
    chk("reset m_ready", m_ready, 1);
    chk("reset wr_en", wr_en, 0);
    chk("reset wr_addr", wr_addr, 0);
    chk("reset wr_data", wr_data, 0);
    chk("reset busy1", busy1, 0);
    resetn = 1;

    //          pv pa pd    mv ma md    ie ir r1 r2  pr mr we wa wd    b1 b2
    tbl.push_back(mk(1, 5, 'hA5, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 0, 0,   0, 0));
    tbl.push_back(mk(0, 0, 0,   0, 0, 0,   0, 0, 0, 0, 1, 1, 1, 5, 'hA5, 0, 0));
    tbl.push_back(mk(1, 1, 'h11, 1, 7, 'h77, 0, 0, 0, 0, 1, 0, 0, 0, 0,   0, 0));
    tbl.push_back(mk(1, 2, 'h12, 1, 7, 'h77, 0, 0, 0, 0, 1, 0, 1, 1, 'h11, 0, 0));
    tbl.push_back(mk(1, 3, 'h13, 1, 7, 'h77, 0, 0, 0, 0, 1, 0, 1, 2, 'h12, 0, 0));
    tbl.push_back(mk(1, 4, 'h14, 1, 7, 'h77, 0, 0, 0, 0, 1, 0, 1, 3, 'h13, 0, 0));
    tbl.push_back(mk(1, 6, 'h15, 1, 7, 'h77, 0, 0, 0, 0, 0, 1, 1, 4, 'h14, 0, 0));
    tbl.push_back(mk(0, 0, 0,   0, 0, 0,   0, 0, 0, 0, 1, 1, 1, 7, 'h77, 0, 0));
    tbl.push_back(mk(0, 0, 0,   0, 0, 0,   1, 9, 9, 0, 1, 1, 0, 0, 0,   0, 0));
    tbl.push_back(mk(0, 0, 0,   1, 9, 'h99, 0, 0, 9, 0, 1, 1, 0, 0, 0,   1, 0));
    tbl.push_back(mk(0, 0, 0,   0, 0, 0,   0, 0, 9, 0, 1, 1, 1, 9, 'h99, 0, 0));
    tbl.push_back(mk(0, 0, 0,   0, 0, 0,   1, 3, 0, 3, 1, 1, 0, 0, 0,   0, 0));
    tbl.push_back(mk(0, 0, 0,   1, 3, 'h33, 1, 3, 0, 3, 1, 1, 0, 0, 0,   0, 1));
    tbl.push_back(mk(0, 0, 0,   0, 0, 0,   0, 0, 0, 3, 1, 1, 1, 3, 'h33, 0, 1));
    tbl.push_back(mk(1, 0, 'hFF, 0, 0, 0,   1, 0, 0, 0, 1, 0, 0, 0, 0,   0, 0));
    tbl.push_back(mk(0, 0, 0,   0, 0, 0,   0, 0, 0, 0, 1, 1, 0, 0, 0,   0, 0));
    tbl.push_back(mk(0, 0, 0,   1, 3, 'h34, 0, 0, 0, 3, 1, 1, 0, 0, 0,   0, 1));
    tbl.push_back(mk(0, 0, 0,   0, 0, 0,   0, 0, 0, 3, 1, 1, 1, 3, 'h34, 0, 0));

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      p_valid = tbl[i].pv; p_addr = tbl[i].pa; p_data = tbl[i].pd;
      m_valid = tbl[i].mv; m_addr = tbl[i].ma; m_data = tbl[i].md;
      issue_en = tbl[i].ie; issue_rd = tbl[i].ir;
      rs1 = tbl[i].r1; rs2 = tbl[i].r2;
      #1;
      $display("row %0d: p %0b/%0b m %0b/%0b wr %0b @%0d = %0h", i,
               p_valid, p_ready, m_valid, m_ready, wr_en, wr_addr, wr_data);
      chk($sformatf("row%0d p_ready", i), p_ready, tbl[i].e_pr);
      chk($sformatf("row%0d m_ready", i), m_ready, tbl[i].e_mr);
      chk($sformatf("row%0d wr_en", i), wr_en, tbl[i].e_we);
      if (tbl[i].e_we) begin
        chk($sformatf("row%0d wr_addr", i), wr_addr, tbl[i].e_wa);
        chk($sformatf("row%0d wr_data", i), wr_data, tbl[i].e_wd);
      end
      chk($sformatf("row%0d busy1", i), busy1, tbl[i].e_b1);
      chk($sformatf("row%0d busy2", i), busy2, tbl[i].e_b2);
    end

    // Reset while in M_PRIO with a write on the port and a register pending.
    @(posedge clk); #1;
    drive_idle();
    issue_en = 1; issue_rd = 12;
    @(posedge clk); #1;
    issue_en = 0; rs1 = 12;
    p_valid = 1; p_addr = 10; p_data = 'hBEEF;
    m_valid = 1; m_addr = 14; m_data = 'h1414;
    repeat (STARVE_LIMIT) begin
      @(posedge clk); #1;
    end
    chk("pre-reset wr_en", wr_en, 1);
    chk("pre-reset wr_addr", wr_addr, 10);
    chk("pre-reset p_ready", p_ready, 0);
    chk("pre-reset busy1", busy1, 1);
    resetn = 0;
    #1;
    chk("in-reset wr_en", wr_en, 0);
    chk("in-reset wr_addr", wr_addr, 0);
    chk("in-reset wr_data", wr_data, 0);
    chk("in-reset busy1", busy1, 0);
    chk("in-reset p_ready", p_ready, 1);
    chk("in-reset m_ready", m_ready, 0);
    drive_idle();
    @(posedge clk); #1;
    resetn = 1;
    @(posedge clk); #1;
    chk("post-reset wr_en", wr_en, 0);
    p_valid = 1; p_addr = 11; p_data = 'h77;
    #1;
    chk("post-reset p_ready", p_ready, 1);
    @(posedge clk); #1;
    chk("post-reset write en", wr_en, 1);
    chk("post-reset write addr", wr_addr, 11);
    chk("post-reset write data", wr_data, 'h77);
    drive_idle();

    // Random traffic; model starts from the post-reset, idle state.
    refused = 0;
    foreach (pend[k]) pend[k] = 0;
    exp_we = 0; exp_wa = '0; exp_wd = '0;
    for (int c = 0; c < 3000; c++) begin
      bit m_turn, e_pr, e_mr, pxf, mxf;
      @(posedge clk); #1;
      chk("rnd wr_en", wr_en, exp_we);
      if (exp_we) begin
        chk("rnd wr_addr", wr_addr, exp_wa);
        chk("rnd wr_data", wr_data, exp_wd);
      end
      p_valid  = ($urandom_range(0, 9) < 7);
      p_addr   = AW'($urandom_range(0, 7));
      p_data   = $urandom;
      m_valid  = ($urandom_range(0, 9) < 6);
      m_addr   = AW'($urandom_range(0, 7));
      m_data   = $urandom;
      issue_en = ($urandom_range(0, 3) == 0);
      issue_rd = AW'($urandom_range(0, 7));
      rs1      = AW'($urandom_range(0, 7));
      rs2      = AW'($urandom_range(0, 31));
      #1;
      // M earns the port once it has been turned away STARVE_LIMIT times in a row.
      m_turn = (refused >= STARVE_LIMIT);
      e_pr = !m_turn;
      e_mr = m_turn || !p_valid;
      chk("rnd p_ready", p_ready, e_pr);
      chk("rnd m_ready", m_ready, e_mr);
      chk("rnd busy1", busy1, (rs1 != 0) && pend[rs1]);
      chk("rnd busy2", busy2, (rs2 != 0) && pend[rs2]);
      pxf = p_valid && e_pr;
      mxf = m_valid && e_mr;
      exp_we = (pxf && p_addr != 0) || (mxf && m_addr != 0);
      exp_wa = mxf ? m_addr : p_addr;
      exp_wd = mxf ? m_data : p_data;
      if (!m_valid || mxf) refused = 0;
      else refused++;
      if (mxf) pend[m_addr] = 0;
      if (issue_en && issue_rd != 0) pend[issue_rd] = 1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
